mdu_iterative: RTL and testbench

- RV32M multiply/divide unit. Sits directly downstream of the register file read ports (operands from rd1/rd2) and upstream of its write port (result drives wd3/a3/we3 through the writeback mux).
- Iterative radix-2 datapath: one shared 32-step shift-add / restoring-subtract engine. Multi-cycle, start/done handshake; the core stalls while busy.

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mdu_iterative.sv | 167 ++++++++++++++++
 tb/tb_mdu_iterative.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package mdu_pkg;

    localparam int XLEN = 32;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } mdu_state_e;

    localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

    // Magnitude of v when it is to be treated as signed; INT_MIN maps to 2^31 as unsigned.
    function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mdu_iterative.sv
// RV32M multiply/divide unit: one radix-2 engine shared by shift-add multiply
// and restoring divide, sequenced by a five-state FSM with start/done handshake.
module mdu_iterative #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    input  logic [REG_AW-1:0] rd_in,
    input  logic              kill,
    output logic              busy,
    output logic              done,
    output logic              we_out,
    output logic [REG_AW-1:0] rd_out,
    output logic [XLEN-1:0]   result
);
    import mdu_pkg::*;

    mdu_state_e          state_reg, state_next;
    mdu_op_e             op_reg;
    logic [XLEN-1:0]     a_reg, b_reg;      // raw operands until PREP, then b_reg holds |b|
    logic [2*XLEN-1:0]   acc_reg;           // {hi,lo} product or {rem,quot}
    logic [4:0]          cnt_reg;
    logic                neg_reg;           // negate the selected result word in FIX
    logic [XLEN-1:0]     result_reg;
    logic [REG_AW-1:0]   rd_reg;

    logic                is_div, is_rem, a_signed, b_signed;
    logic                div_zero, div_ovf, special;
    logic [XLEN-1:0]     special_value;
    logic                sign_a, sign_b;

    // Operation decode and special divide detection (meaningful in PREP, while operands are raw)
    always_comb begin
        is_div        = op_reg[2];
        is_rem        = op_reg[2] & op_reg[1];
        a_signed      = (op_reg == OP_MULH) || (op_reg == OP_MULHSU) ||
                        (op_reg == OP_DIV)  || (op_reg == OP_REM);
        b_signed      = (op_reg == OP_MULH) || (op_reg == OP_DIV) || (op_reg == OP_REM);
        sign_a        = a_signed & a_reg[XLEN-1];
        sign_b        = b_signed & b_reg[XLEN-1];
        div_zero      = is_div && (b_reg == '0);
        div_ovf       = is_div && a_signed && (a_reg == INT_MIN) && (b_reg == '1);
        special       = div_zero || div_ovf;
        special_value = '0;
        if (div_zero)
            special_value = is_rem ? a_reg : DIV0_QUOT;
        else if (div_ovf)
            special_value = is_rem ? '0 : INT_MIN;
    end

    logic [XLEN:0]       add_sum;
    logic [2*XLEN-1:0]   shl;
    logic                trial_ge;
    logic [XLEN-1:0]     trial_diff;
    logic [2*XLEN-1:0]   acc_step;

    // One step of the shared engine: add-then-shift-right for multiply, shift-left-then-trial-subtract for divide
    always_comb begin
        add_sum    = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, b_reg} : {(XLEN+1){1'b0}});
        shl        = {acc_reg[2*XLEN-2:0], 1'b0};
        // bit shifted out of the remainder is the 33rd bit of the trial dividend
        trial_ge   = acc_reg[2*XLEN-1] || (shl[2*XLEN-1:XLEN] >= b_reg);
        trial_diff = shl[2*XLEN-1:XLEN] - b_reg;
        if (is_div)
            acc_step = trial_ge ? {trial_diff, shl[XLEN-1:1], 1'b1} : shl;
        else
            acc_step = {add_sum, acc_reg[XLEN-1:1]};
    end

    logic [2*XLEN-1:0]   prod_signed;
    logic [XLEN-1:0]     div_word;
    logic [XLEN-1:0]     fix_value;

    // Sign correction and word selection applied in FIX
    always_comb begin
        prod_signed = neg_reg ? (~acc_reg + 1'b1) : acc_reg;
        div_word    = is_rem ? acc_reg[2*XLEN-1:XLEN] : acc_reg[XLEN-1:0];
        if (is_div)
            fix_value = neg_reg ? (~div_word + 1'b1) : div_word;
        else if (op_reg == OP_MUL)
            fix_value = prod_signed[XLEN-1:0];
        else
            fix_value = prod_signed[2*XLEN-1:XLEN];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic; kill aborts any working state but never a finished one
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start && !kill) state_next = PREP;
            PREP: state_next = kill ? IDLE : (special ? DONE : CALC);
            CALC: if (kill) state_next = IDLE;
                  else if (cnt_reg == '0) state_next = FIX;
            FIX:  state_next = kill ? IDLE : DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers; result only changes on a completed (non-killed) operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg     <= OP_MUL;
            a_reg      <= '0;
            b_reg      <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
            result_reg <= '0;
            rd_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && !kill) begin
                        op_reg <= mdu_op_e'(funct3);
                        a_reg  <= op_a;
                        b_reg  <= op_b;
                        rd_reg <= rd_in;
                    end
                end
                PREP: begin
                    if (!kill) begin
                        if (special) begin
                            result_reg <= special_value;
                        end else begin
                            acc_reg <= {{XLEN{1'b0}}, abs_if(a_reg, a_signed)};
                            b_reg   <= abs_if(b_reg, b_signed);
                            neg_reg <= is_rem ? sign_a : (sign_a ^ sign_b);
                            cnt_reg <= 5'd31;
                        end
                    end
                end
                CALC: begin
                    if (!kill) begin
                        acc_reg <= acc_step;
                        cnt_reg <= cnt_reg - 5'd1;
                    end
                end
                FIX: begin
                    if (!kill)
                        result_reg <= fix_value;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_reg == PREP) || (state_reg == CALC) || (state_reg == FIX);
    assign done   = (state_reg == DONE);
    assign we_out = done && (rd_reg != '0);
    assign rd_out = rd_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed RV32M cases, abort cases and
// random operations compared against a plain-arithmetic reference model.
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        kill;
    logic        busy, done, we_out;
    logic [4:0]  rd_out;
    logic [31:0] result;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    logic [31:0] last_exp = 32'h0;

    mdu_iterative #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .kill(kill),
        .busy(busy), .done(done), .we_out(we_out), .rd_out(rd_out), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // RV32M semantics in plain 64-bit arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges after the sampling edge until done is visible: 1 for the special divides, 34 otherwise
    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issue one op from IDLE (called #1 after an edge) and check everything about its completion
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        logic [31:0] expv;
        int lat;
        bit seen;
        expv = ref_op(f, a, b);
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom); funct3 = 3'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        lat = 0; seen = 0;
        while (!seen && lat < 100) begin
            if (done) seen = 1;
            else begin @(posedge clk); #1; lat++; end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(ref_lat(f, a, b)));
        check("result", result, expv);
        check("rd_out", 32'(rd_out), 32'(rd));
        check("we_out", 32'(we_out), 32'(rd != 0));
        check("busy_in_done", 32'(busy), 32'd0);
        $display("op f=%0d a=%h b=%h rd=%0d -> result=%h expected=%h lat=%0d", f, a, b, rd, result, expv, lat);
        last_exp = expv;
        @(posedge clk); #1;
        check("done_single_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        int pulses;
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        int sel;

        rst_n = 1'b0; start = 1'b0; kill = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0; rd_in = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(we_out), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd", 32'(rd_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // directed arithmetic
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
        do_op(3'd5, 32'd100, 32'd7, 5'd7);
        do_op(3'd7, 32'd100, 32'd7, 5'd8);
        do_op(3'd5, 32'h1234, 32'd0, 5'd9);
        do_op(3'd6, 32'h1234, 32'd0, 5'd10);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        do_op(3'd0, 32'd9, 32'd9, 5'd0);

        // kill in IDLE overrides start
        funct3 = 3'd0; op_a = 32'd5; op_b = 32'd5; rd_in = 5'd1; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("kill_idle_busy", 32'(busy), 32'd0);
        $display("kill in IDLE with start: busy=%0d", busy);

        // kill 10 cycles into CALC
        funct3 = 3'd0; op_a = 32'd123; op_b = 32'd456; rd_in = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) begin @(posedge clk); #1; end
        check("busy_before_kill", 32'(busy), 32'd1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_busy", 32'(busy), 32'd0);
        pulses = 0;
        repeat (40) begin if (done) pulses++; @(posedge clk); #1; end
        check("kill_no_done", 32'(pulses), 32'd0);
        check("kill_result_kept", result, last_exp);
        $display("kill mid-CALC: busy=%0d done_pulses=%0d result=%h", busy, pulses, result);

        // asynchronous reset mid-CALC
        funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_we", 32'(we_out), 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_rd", 32'(rd_out), 32'd0);
        $display("async reset mid-CALC: busy=%0d result=%h rd_out=%0d", busy, result, rd_out);
        #3 rst_n = 1'b1;
        last_exp = 32'd0;
        @(posedge clk); #1;
        do_op(3'd0, 32'd3, 32'd4, 5'd13);

        // start held high: one done, then the next op is accepted only from IDLE
        funct3 = 3'd3; op_a = 32'h8000_0001; op_b = 32'h0000_0010; rd_in = 5'd14; start = 1'b1;
        @(posedge clk); #1;
        pulses = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
            if (k == 35) check("held_idle_gap", 32'(busy), 32'd0);
            if (k == 36) check("held_reaccept", 32'(busy), 32'd1);
        end
        check("held_one_done", 32'(pulses), 32'd1);
        start = 1'b0;
        pulses = 0;
        while (!done && pulses < 60) begin @(posedge clk); #1; pulses++; end
        check("held_second_done", 32'(done), 32'd1);
        check("held_second_result", result, ref_op(3'd3, 32'h8000_0001, 32'h0000_0010));
        $display("start held: second result=%h", result);
        last_exp = ref_op(3'd3, 32'h8000_0001, 32'h0000_0010);
        @(posedge clk); #1;

        // random operations
        for (int i = 0; i < 30; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            do_op(rf, ra, rb, 5'($urandom_range(0, 31)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
